accel_avg_filter: RTL and testbench

- Downstream consumer of the SPI accelerometer controller; sits in the `clk` domain.
- Takes the one-cycle `data_update` pulse and the three 16-bit axis words, and keeps a per-axis moving average over the last 2^LOG2_DEPTH samples.
- One adder/subtractor is shared across the axes and processes X, Y, Z serially.
- Presents the filtered axes with a one-cycle `avg_valid` strobe, plus a primed flag and a dropped-sample counter, to display/application logic.

---
 rtl/accel_avg_filter.sv | 111 +++++++++++
 tb/tb_accel_avg_filter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/accel_avg_filter.sv
// accel_avg_filter: per-axis moving average over 2^LOG2_DEPTH samples,
// one shared adder stepping through X, Y and Z on consecutive cycles.
module accel_avg_filter #(
    parameter int LOG2_DEPTH = 3,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              data_update,
    input  logic [DATA_W-1:0] data_x,
    input  logic [DATA_W-1:0] data_y,
    input  logic [DATA_W-1:0] data_z,
    output logic [DATA_W-1:0] avg_x,
    output logic [DATA_W-1:0] avg_y,
    output logic [DATA_W-1:0] avg_z,
    output logic              avg_valid,
    output logic              primed,
    output logic [7:0]        drop_count
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = DATA_W + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, UPD_X, UPD_Y, UPD_Z, DONE} state_t;

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] hist_q [3][DEPTH];
    logic signed [DATA_W-1:0] hist_d [3][DEPTH];
    logic signed [SW-1:0]     sum_q [3];
    logic signed [SW-1:0]     sum_d [3];
    logic signed [DATA_W-1:0] hold_q [3];
    logic signed [DATA_W-1:0] hold_d [3];
    logic signed [DATA_W-1:0] avg_q [3];
    logic signed [DATA_W-1:0] avg_d [3];
    logic [LOG2_DEPTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH:0]      fill_q, fill_d;
    logic                     primed_q, primed_d;
    logic [7:0]               drop_q, drop_d;
    logic                     upd, last;
    logic [1:0]               ax;
    logic signed [SW-1:0]     new_sum;

    function automatic logic signed [SW-1:0] sx(input logic signed [DATA_W-1:0] v);
        return {{LOG2_DEPTH{v[DATA_W-1]}}, v};
    endfunction

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;

    always_comb
        state_d = state_q == IDLE ? (data_update ? UPD_X : IDLE) :
                  state_q == DONE ? IDLE : state_t'(state_q + 3'd1);

    always_comb begin
        upd       = state_q inside {UPD_X, UPD_Y, UPD_Z};
        last      = state_q == UPD_Z;
        ax        = state_q == UPD_Y ? 2'd1 : state_q == UPD_Z ? 2'd2 : 2'd0;
        avg_valid = state_q == DONE;
    end

    // The axis selected by the state owns the shared adder this cycle.
    always_comb begin
        hist_d  = hist_q;
        sum_d   = sum_q;
        avg_d   = avg_q;
        hold_d  = hold_q;
        new_sum = sum_q[ax] - sx(hist_q[ax][wr_ptr_q]) + sx(hold_q[ax]);
        if (state_q == IDLE && data_update) begin
            hold_d[0] = data_x;
            hold_d[1] = data_y;
            hold_d[2] = data_z;
        end
        if (upd) begin
            hist_d[ax][wr_ptr_q] = hold_q[ax];
            sum_d[ax]            = new_sum;
            avg_d[ax]            = new_sum[SW-1:LOG2_DEPTH];
        end
        wr_ptr_d = last ? wr_ptr_q + LOG2_DEPTH'(1) : wr_ptr_q;
        fill_d   = last && fill_q != FULL ? fill_q + (LOG2_DEPTH+1)'(1) : fill_q;
        primed_d = primed_q | (fill_d == FULL);
        drop_d   = data_update && state_q != IDLE && drop_q != 8'hFF ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            hist_q   <= '{default: '0};
            sum_q    <= '{default: '0};
            hold_q   <= '{default: '0};
            avg_q    <= '{default: '0};
            wr_ptr_q <= '0;
            fill_q   <= '0;
            primed_q <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            hist_q   <= hist_d;
            sum_q    <= sum_d;
            hold_q   <= hold_d;
            avg_q    <= avg_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            primed_q <= primed_d;
            drop_q   <= drop_d;
        end

    assign avg_x      = avg_q[0];
    assign avg_y      = avg_q[1];
    assign avg_z      = avg_q[2];
    assign primed     = primed_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_accel_avg_filter.sv
// tb_accel_avg_filter: three filter instances (windows 4, 2, 32) sharing data
// and reset; a windowed-sum model feeds an expected-result queue.
module tb_accel_avg_filter;
    typedef struct {
        logic signed [15:0] x, y, z;
        logic               p;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               du = 1'b0;
    int                 sel = 0;
    logic signed [15:0] dx = '0, dy = '0, dz = '0;
    logic signed [15:0] ox [3], oy [3], oz [3];
    logic               ov [3], op [3];
    logic [7:0]         od [3];

    int   lg [3] = '{2, 1, 5};
    int   h [3][3][32];
    int   ptr [3], cnt [3], drops [3];
    exp_t q [$];
    int   checks = 0, errors = 0;

    always #5 clk = ~clk;

    accel_avg_filter #(.LOG2_DEPTH(2), .DATA_W(16)) u_d4 (
        .clk(clk), .reset_n(rst_n), .data_update(du && sel == 0),
        .data_x(dx), .data_y(dy), .data_z(dz),
        .avg_x(ox[0]), .avg_y(oy[0]), .avg_z(oz[0]),
        .avg_valid(ov[0]), .primed(op[0]), .drop_count(od[0]));
    accel_avg_filter #(.LOG2_DEPTH(1), .DATA_W(16)) u_d2 (
        .clk(clk), .reset_n(rst_n), .data_update(du && sel == 1),
        .data_x(dx), .data_y(dy), .data_z(dz),
        .avg_x(ox[1]), .avg_y(oy[1]), .avg_z(oz[1]),
        .avg_valid(ov[1]), .primed(op[1]), .drop_count(od[1]));
    accel_avg_filter #(.LOG2_DEPTH(5), .DATA_W(16)) u_d32 (
        .clk(clk), .reset_n(rst_n), .data_update(du && sel == 2),
        .data_x(dx), .data_y(dy), .data_z(dz),
        .avg_x(ox[2]), .avg_y(oy[2]), .avg_z(oz[2]),
        .avg_valid(ov[2]), .primed(op[2]), .drop_count(od[2]));

    task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 3; s++) begin
            ptr[s] = 0;
            cnt[s] = 0;
            drops[s] = 0;
            for (int a = 0; a < 3; a++)
                for (int i = 0; i < 32; i++) h[s][a][i] = 0;
        end
        q.delete();
    endtask

    task automatic chk_zero(int s);
        chk("rst_x", ox[s], 0);
        chk("rst_y", oy[s], 0);
        chk("rst_z", oz[s], 0);
        chk("rst_valid", ov[s], 0);
        chk("rst_primed", op[s], 0);
        chk("rst_drop", od[s], 0);
    endtask

    // Called on a negedge; returns on the negedge after the DONE cycle.
    task automatic send(int s, int x, int y, int z, bit d2 = 0, bit dd = 0);
        exp_t               e;
        longint             sum;
        logic signed [15:0] r [3];
        int                 n = 1 << lg[s];
        h[s][0][ptr[s]] = x;
        h[s][1][ptr[s]] = y;
        h[s][2][ptr[s]] = z;
        ptr[s] = (ptr[s] + 1) % n;
        if (cnt[s] < n) cnt[s]++;
        for (int a = 0; a < 3; a++) begin
            sum = 0;
            for (int i = 0; i < n; i++) sum += h[s][a][i];
            r[a] = 16'(sum >>> lg[s]);
        end
        e.x = r[0];
        e.y = r[1];
        e.z = r[2];
        e.p = cnt[s] == n;
        q.push_back(e);
        sel = s;
        dx = 16'(x);
        dy = 16'(y);
        dz = 16'(z);
        du = 1'b1;
        @(negedge clk);
        du = 1'b0;
        @(negedge clk);
        if (d2) begin
            dx = 16'sd7777;
            dy = 16'sd7777;
            dz = 16'sd7777;
            du = 1'b1;
        end
        @(negedge clk);
        du = 1'b0;
        @(negedge clk);
        chk("valid", ov[s], 1);
        if (ov[s] === 1'b1 && q.size() > 0) begin
            e = q.pop_front();
            chk("avg_x", ox[s], e.x);
            chk("avg_y", oy[s], e.y);
            chk("avg_z", oz[s], e.z);
            chk("primed", op[s], e.p);
        end
        if (dd) du = 1'b1;
        @(negedge clk);
        du = 1'b0;
        chk("valid_one_cycle", ov[s], 0);
        drops[s] = drops[s] + int'(d2) + int'(dd);
        if (drops[s] > 255) drops[s] = 255;
        chk("drop_count", od[s], drops[s]);
    endtask

    initial begin
        clear_model();
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) chk_zero(s);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 4; k++) send(0, 100, -100, 256);
        chk("warm_x", ox[0], 100);
        chk("warm_z", oz[0], 256);
        chk("primed_4", op[0], 1);

        send(0, 500, -100, 256);
        chk("step_x", ox[0], 200);
        for (int k = 0; k < 4; k++) send(0, 500, -100, 256);
        chk("settle_x", ox[0], 500);

        send(1, -1, 0, 0);
        send(1, -2, 0, 0);
        chk("floor_x", ox[1], -2);

        send(0, 40, 41, 42, 1, 1);
        chk("drops_2", od[0], 2);
        send(0, 12, -12, 4);

        for (int k = 0; k < 32; k++) send(2, -32768, 0, 32767);
        chk("fs_x", ox[2], -32768);
        chk("fs_z", oz[2], 32767);
        chk("fs_primed", op[2], 1);

        sel = 0;
        dx = 16'sd1000;
        dy = 16'sd8;
        dz = -16'sd8;
        du = 1'b1;
        @(negedge clk);
        du = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero(0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        send(0, 1000, 8, -8);
        chk("post_rst_x", ox[0], 250);
        chk("post_rst_primed", op[0], 0);

        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
